layer_scheduler: RTL and testbench
==================================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter MAX_LAYERS, default 8: descriptor-table depth and maximum layers per run.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  one-cycle pulse that starts a network run; sampled only in IDLE.
REQ-005 abort  in  1  synchronous abort of the current run.
REQ-006 num_layers  in  4  number of layers in the run; legal range 1..MAX_LAYERS.
REQ-007 cfg_we  in  1  descriptor write enable.
REQ-008 cfg_addr  in  3  descriptor index.
REQ-009 cfg_wdata  in  29  descriptor fields: [28:13] image_size, [12:7] number_channel, [6:3] kernel_size, [2] padding, [1:0] stride.
REQ-010 layer_done  in  1  one-cycle pulse from the IF/PE datapath when the current layer finishes.
REQ-011 image_size  out  16; number_channel  out  6; kernel_size  out  4; padding  out  1; stride  out  2: registered configuration of the current layer.
REQ-012 port_input  out  port_sel_t  ping-pong input BRAM select (BRAM_A/BRAM_B).
REQ-013 layer_start  out  1  one-cycle start pulse to the IF controller.
REQ-014 layer_idx  out  3  index of the current layer.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 net_done  out  1  one-cycle pulse when a run completes normally.
REQ-017 cfg_err  out  1  one-cycle pulse when a run is rejected or aborted because of a configuration error.

Function
REQ-018 States SHALL be IDLE, LOAD, START, WAIT, NEXT and DONE.
REQ-019 IDLE, start=1 with num_layers in 1..MAX_LAYERS: clear layer_idx to 0, set port_input=BRAM_A, go to LOAD.
REQ-020 IDLE, start=1 with num_layers=0 or num_layers>MAX_LAYERS: pulse cfg_err for one cycle and stay in IDLE.
REQ-021 LOAD: register table[layer_idx] onto the configuration outputs.
  - If that descriptor has stride=0 or kernel_size=0: pulse cfg_err and go to IDLE.
  - Otherwise go to START.
REQ-022 START: layer_start=1 for exactly one cycle, then go to WAIT.
REQ-023 WAIT: hold all outputs until layer_done=1, then go to NEXT.
REQ-024 layer_done SHALL be ignored in every state except WAIT.
REQ-025 NEXT:
  - If layer_idx = num_layers-1: go to DONE.
  - Otherwise: toggle port_input, increment layer_idx, go to LOAD.
REQ-026 DONE: pulse net_done for one cycle, then go to IDLE.
REQ-027 Latency:
  - start at cycle T -> layer_start at T+2.
  - layer_done at cycle N (not the last layer) -> next layer_start at N+3.
  - layer_done on the last layer at N -> net_done at N+2.
REQ-028 num_layers SHALL be captured on start; later changes SHALL NOT affect the run in progress.
REQ-029 cfg_we SHALL write the table only when busy=0; writes while busy=1 SHALL be dropped.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
  - No net_done, no cfg_err.
  - abort has priority over a layer_done arriving in the same cycle.
REQ-032 Configuration outputs and port_input SHALL retain their last values in IDLE.

Reset
REQ-033 rst=1 SHALL asynchronously force the following, regardless of state:
  - state=IDLE, layer_idx=0, port_input=BRAM_A;
  - all configuration outputs = 0;
  - layer_start=0, busy=0, net_done=0, cfg_err=0.
REQ-034 Reset SHALL clear the descriptor table to all zeros; rst asserted mid-run SHALL abandon the run without any pulse.

Structure
REQ-035 Shared package bnn_pkg SHALL hold:
  - port_sel_t enum {BRAM_A, BRAM_B};
  - layer_desc_t packed struct matching REQ-009;
  - sched_state_t;
  - MAX_LAYERS default.
REQ-036 The descriptor table SHALL be a sub-module, layer_desc_regfile: MAX_LAYERS x 29-bit registers, combinational read, synchronous write, asynchronous reset.

Verification
REQ-037 num_layers=2, table[0]={28,1,3,1,1}, table[1]={14,32,3,1,1}; start at cycle 0, layer_done at cycles 10 and 20:
  - layer_start at cycles 2 and 13;
  - port_input=BRAM_A for layer 0, BRAM_B for layer 1;
  - net_done at cycle 22.
REQ-038 num_layers=0, start -> cfg_err pulse the following cycle; busy stays 0.
REQ-039 table[1].stride=0, num_layers=3 -> cfg_err during layer 1's LOAD; no second layer_start; returns to IDLE.
REQ-040 abort and layer_done asserted together in WAIT -> IDLE next cycle; no net_done.
REQ-041 cfg_we to address 0 while busy -> table[0] unchanged after the run (read back through a second run).
REQ-042 rst asserted mid-WAIT, between clock edges -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types for the BNN layer scheduler: BRAM select, descriptor layout, FSM states.
package bnn_pkg;

   localparam int MAX_LAYERS_DEFAULT = 8;
   localparam int DESC_W             = 29;

   typedef enum logic {
      BRAM_A = 1'b0,
      BRAM_B = 1'b1
   } port_sel_t;

   typedef struct packed {
      logic [15:0] image_size;
      logic [5:0]  number_channel;
      logic [3:0]  kernel_size;
      logic        padding;
      logic [1:0]  stride;
   } layer_desc_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } sched_state_t;

   // A layer cannot be run with a zero stride or a zero-sized kernel.
   function automatic logic desc_valid(input layer_desc_t d);
      return (d.stride != 2'd0) && (d.kernel_size != 4'd0);
   endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Control/configuration bundle between the network controller and the layer scheduler.
interface layer_scheduler_if;
   import bnn_pkg::*;

   logic        start;
   logic        abort;
   logic [3:0]  num_layers;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [28:0] cfg_wdata;
   logic        layer_done;

   logic [15:0] image_size;
   logic [5:0]  number_channel;
   logic [3:0]  kernel_size;
   logic        padding;
   logic [1:0]  stride;
   port_sel_t   port_input;
   logic        layer_start;
   logic [2:0]  layer_idx;
   logic        busy;
   logic        net_done;
   logic        cfg_err;

   // Controller side: issues runs, programs descriptors, reports layer completion.
   modport master (
      output start, abort, num_layers, cfg_we, cfg_addr, cfg_wdata, layer_done,
      input  image_size, number_channel, kernel_size, padding, stride,
      input  port_input, layer_start, layer_idx, busy, net_done, cfg_err
   );

   // Scheduler side.
   modport slave (
      input  start, abort, num_layers, cfg_we, cfg_addr, cfg_wdata, layer_done,
      output image_size, number_channel, kernel_size, padding, stride,
      output port_input, layer_start, layer_idx, busy, net_done, cfg_err
   );

endinterface

// File: rtl/layer_desc_regfile.sv
// Descriptor table: one register per layer, synchronous write, combinational read.
module layer_desc_regfile
   import bnn_pkg::*;
#(
   parameter int MAX_LAYERS = MAX_LAYERS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [2:0]  waddr,
   input  layer_desc_t wdata,
   input  logic [2:0]  raddr,
   output layer_desc_t rdata
);

   layer_desc_t entries [MAX_LAYERS];

   generate
      for (genvar gi = 0; gi < MAX_LAYERS; gi++) begin : g_entry
         layer_desc_t entry_reg;

         // Each entry loads only when its own address is written.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (we && (waddr == 3'(gi))) begin
               entry_reg <= wdata;
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   // Addresses beyond the table depth read back as an all-zero (invalid) descriptor.
   assign rdata = (int'(raddr) < MAX_LAYERS) ? entries[raddr] : '0;

endmodule

// File: rtl/layer_scheduler.sv
// Layer scheduler: steps through the descriptor table, presenting each layer's
// configuration and a start pulse to the IF/PE datapath, alternating input BRAMs.
module layer_scheduler
   import bnn_pkg::*;
#(
   parameter int MAX_LAYERS = MAX_LAYERS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   layer_scheduler_if.slave bus
);

   localparam logic [3:0] MAX_LAYERS_4 = 4'(MAX_LAYERS);

   sched_state_t state_reg;
   logic [3:0]   num_layers_reg;
   logic [2:0]   layer_idx_reg;
   port_sel_t    port_input_reg;
   layer_desc_t  cfg_reg;
   logic         layer_start_reg;
   logic         busy_reg;
   logic         net_done_reg;
   logic         cfg_err_reg;

   layer_desc_t  table_rdata;
   logic         table_we;
   logic         num_ok;
   logic         last_layer;

   // Table is frozen for the whole run so the layers being executed cannot change under it.
   assign table_we   = bus.cfg_we & ~busy_reg;
   assign num_ok     = (bus.num_layers != 4'd0) && (bus.num_layers <= MAX_LAYERS_4);
   assign last_layer = ({1'b0, layer_idx_reg} == (num_layers_reg - 4'd1));

   layer_desc_regfile #(
      .MAX_LAYERS(MAX_LAYERS)
   ) u_desc_table (
      .clk   (clk),
      .rst   (rst),
      .we    (table_we),
      .waddr (bus.cfg_addr),
      .wdata (layer_desc_t'(bus.cfg_wdata)),
      .raddr (layer_idx_reg),
      .rdata (table_rdata)
   );

   // Run sequencing FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         num_layers_reg  <= 4'd0;
         layer_idx_reg   <= 3'd0;
         port_input_reg  <= BRAM_A;
         cfg_reg         <= '0;
         layer_start_reg <= 1'b0;
         busy_reg        <= 1'b0;
         net_done_reg    <= 1'b0;
         cfg_err_reg     <= 1'b0;
      end else begin
         layer_start_reg <= 1'b0;
         net_done_reg    <= 1'b0;
         cfg_err_reg     <= 1'b0;

         if (bus.abort && (state_reg != IDLE)) begin
            // Abort wins over everything, including a simultaneous layer_done.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (bus.start) begin
                     if (num_ok) begin
                        num_layers_reg <= bus.num_layers;
                        layer_idx_reg  <= 3'd0;
                        port_input_reg <= BRAM_A;
                        busy_reg       <= 1'b1;
                        state_reg      <= LOAD;
                     end else begin
                        cfg_err_reg <= 1'b1;
                     end
                  end
               end

               LOAD: begin
                  cfg_reg <= table_rdata;
                  if (!desc_valid(table_rdata)) begin
                     cfg_err_reg <= 1'b1;
                     busy_reg    <= 1'b0;
                     state_reg   <= IDLE;
                  end else begin
                     layer_start_reg <= 1'b1;
                     state_reg       <= START;
                  end
               end

               START: begin
                  state_reg <= WAIT;
               end

               WAIT: begin
                  if (bus.layer_done) begin
                     state_reg <= NEXT;
                  end
               end

               NEXT: begin
                  if (last_layer) begin
                     net_done_reg <= 1'b1;
                     state_reg    <= DONE;
                  end else begin
                     port_input_reg <= (port_input_reg == BRAM_A) ? BRAM_B : BRAM_A;
                     layer_idx_reg  <= layer_idx_reg + 3'd1;
                     state_reg      <= LOAD;
                  end
               end

               DONE: begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end

               default: begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.image_size     = cfg_reg.image_size;
   assign bus.number_channel = cfg_reg.number_channel;
   assign bus.kernel_size    = cfg_reg.kernel_size;
   assign bus.padding        = cfg_reg.padding;
   assign bus.stride         = cfg_reg.stride;
   assign bus.port_input     = port_input_reg;
   assign bus.layer_start    = layer_start_reg;
   assign bus.layer_idx      = layer_idx_reg;
   assign bus.busy           = busy_reg;
   assign bus.net_done       = net_done_reg;
   assign bus.cfg_err        = cfg_err_reg;

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: directed scenarios plus randomized runs checked
// against a run-level model built from the latency and sequencing rules.
module tb_layer_scheduler;
   import bnn_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   layer_scheduler_if bus ();

   layer_scheduler #(.MAX_LAYERS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   logic [28:0] tbl [8];
   logic [28:0] last_cfg    = '0;
   int          last_port   = 0;
   int          gap_tbl [8];
   int          ls_q [$];
   int          nd_q [$];
   int          t0;

   always @(posedge clk) cyc <= cyc + 1;

   // Independent record of the cycle numbers of observed pulses.
   always @(negedge clk) begin
      if (bus.layer_start === 1'b1) ls_q.push_back(cyc);
      if (bus.net_done === 1'b1) nd_q.push_back(cyc);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [28:0] cur_cfg();
      return {bus.image_size, bus.number_channel, bus.kernel_size, bus.padding, bus.stride};
   endfunction

   task automatic check_outs(input string tag, input logic b, input logic ls, input logic nd, input logic ce);
      check_eq({tag, ".busy"},        32'(bus.busy),        32'(b));
      check_eq({tag, ".layer_start"}, 32'(bus.layer_start), 32'(ls));
      check_eq({tag, ".net_done"},    32'(bus.net_done),    32'(nd));
      check_eq({tag, ".cfg_err"},     32'(bus.cfg_err),     32'(ce));
   endtask

   task automatic check_cfg(input string tag, input logic [28:0] exp_cfg, input int exp_port);
      check_eq({tag, ".cfg"},  32'(cur_cfg()),       32'(exp_cfg));
      check_eq({tag, ".port"}, 32'(bus.port_input),  32'(exp_port));
   endtask

   task automatic clear_noise();
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.cfg_we     = 1'b0;
      bus.layer_done = 1'b0;
   endtask

   task automatic write_desc(input int addr, input logic [28:0] data);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 3'(addr);
      bus.cfg_wdata = data;
      step();
      bus.cfg_we = 1'b0;
      tbl[addr]  = data;
   endtask

   function automatic logic [28:0] rand_desc();
      logic [15:0] img = 16'($urandom_range(1, 65535));
      logic [5:0]  ch  = 6'($urandom_range(0, 63));
      logic [3:0]  k   = 4'($urandom_range(1, 15));
      logic        pad = 1'($urandom_range(0, 1));
      logic [1:0]  s   = 2'($urandom_range(1, 3));
      int          r   = $urandom_range(0, 15);
      if (r == 0) k = 4'd0;
      else if (r == 1) s = 2'd0;
      return {img, ch, k, pad, s};
   endfunction

   task automatic idle_cycles(input int k);
      for (int c = 0; c < k; c++) begin
         bus.layer_done = 1'($urandom_range(0, 1));
         bus.abort      = 1'($urandom_range(0, 1));
         step();
         clear_noise();
         check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
         check_cfg("idle", last_cfg, last_port);
      end
   endtask

   // One network run; the current cycle is the one in which start is driven.
   task automatic run(input int n, input int abort_layer, input logic abort_with_done,
                      input int rst_layer, input logic wr0, input string name);
      logic [28:0] d;
      int          p;
      bus.num_layers = 4'(n);
      bus.start      = 1'b1;
      step();
      bus.start = 1'b0;
      if (n < 1 || n > 8) begin
         check_outs({name, ".reject"}, 1'b0, 1'b0, 1'b0, 1'b1);
         check_cfg({name, ".reject"}, last_cfg, last_port);
         step();
         check_outs({name, ".after_reject"}, 1'b0, 1'b0, 1'b0, 1'b0);
         $display("run %s: n=%0d rejected", name, n);
         return;
      end
      check_outs({name, ".load0"}, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         d = tbl[i];
         p = i % 2;
         bus.num_layers = 4'($urandom_range(0, 15));
         step();
         last_cfg  = d;
         last_port = p;
         if (d[6:3] == 4'd0 || d[1:0] == 2'd0) begin
            check_outs({name, ".bad_desc"}, 1'b0, 1'b0, 1'b0, 1'b1);
            check_cfg({name, ".bad_desc"}, d, p);
            step();
            check_outs({name, ".after_bad"}, 1'b0, 1'b0, 1'b0, 1'b0);
            $display("run %s: n=%0d stopped on bad descriptor at layer %0d", name, n, i);
            return;
         end
         check_outs({name, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0);
         check_eq({name, ".idx"}, 32'(bus.layer_idx), 32'(i));
         check_cfg({name, ".start"}, d, p);
         bus.layer_done = 1'($urandom_range(0, 1));
         for (int g = 1; g <= gap_tbl[i]; g++) begin
            step();
            clear_noise();
            check_outs({name, ".wait"}, 1'b1, 1'b0, 1'b0, 1'b0);
            check_eq({name, ".wait_idx"}, 32'(bus.layer_idx), 32'(i));
            check_cfg({name, ".wait"}, d, p);
            if (i == rst_layer) begin
               #2 rst = 1'b1;
               #1;
               check_outs({name, ".rst_async"}, 1'b0, 1'b0, 1'b0, 1'b0);
               check_cfg({name, ".rst_async"}, '0, 0);
               check_eq({name, ".rst_idx"}, 32'(bus.layer_idx), 32'd0);
               for (int k = 0; k < 8; k++) tbl[k] = '0;
               last_cfg  = '0;
               last_port = 0;
               step();
               rst = 1'b0;
               check_outs({name, ".after_rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
               $display("run %s: n=%0d reset during layer %0d", name, n, i);
               return;
            end
            bus.start = ($urandom_range(0, 3) == 0);
            if (wr0 && g == 1) begin
               bus.cfg_we    = 1'b1;
               bus.cfg_addr  = 3'd0;
               bus.cfg_wdata = ~tbl[0];
            end else if ($urandom_range(0, 3) == 0) begin
               bus.cfg_we    = 1'b1;
               bus.cfg_addr  = 3'($urandom_range(0, 7));
               bus.cfg_wdata = 29'($urandom());
            end
            if (g == gap_tbl[i]) begin
               if (i == abort_layer) begin
                  bus.abort      = 1'b1;
                  bus.layer_done = abort_with_done;
                  step();
                  clear_noise();
                  check_outs({name, ".abort"}, 1'b0, 1'b0, 1'b0, 1'b0);
                  check_cfg({name, ".abort"}, d, p);
                  step();
                  check_outs({name, ".after_abort"}, 1'b0, 1'b0, 1'b0, 1'b0);
                  $display("run %s: n=%0d aborted in layer %0d", name, n, i);
                  return;
               end
               bus.layer_done = 1'b1;
            end
         end
         step();
         clear_noise();
         check_outs({name, ".next"}, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         if (i == n - 1) begin
            check_outs({name, ".done"}, 1'b1, 1'b0, 1'b1, 1'b0);
            check_cfg({name, ".done"}, d, p);
            step();
            check_outs({name, ".end"}, 1'b0, 1'b0, 1'b0, 1'b0);
            check_cfg({name, ".retain"}, d, p);
            $display("run %s: n=%0d completed", name, n);
            return;
         end
         check_outs({name, ".load"}, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int n;
      int ab;
      clear_noise();
      bus.num_layers = 4'd0;
      bus.cfg_addr   = 3'd0;
      bus.cfg_wdata  = '0;
      for (int k = 0; k < 8; k++) begin
         tbl[k]     = '0;
         gap_tbl[k] = 1;
      end

      repeat (3) step();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_cfg("reset", '0, 0);
      check_eq("reset.idx", 32'(bus.layer_idx), 32'd0);
      rst = 1'b0;
      step();

      // Two-layer reference run with absolute pulse timing.
      write_desc(0, {16'd28, 6'd1, 4'd3, 1'b1, 2'd1});
      write_desc(1, {16'd14, 6'd32, 4'd3, 1'b1, 2'd1});
      gap_tbl[0] = 8;
      gap_tbl[1] = 7;
      ls_q.delete();
      nd_q.delete();
      t0 = cyc;
      run(2, -1, 1'b0, -1, 1'b0, "two_layer");
      check_eq("two_layer.n_start", 32'(ls_q.size()), 32'd2);
      if (ls_q.size() == 2) begin
         check_eq("two_layer.start0_cyc", 32'(ls_q[0] - t0), 32'd2);
         check_eq("two_layer.start1_cyc", 32'(ls_q[1] - t0), 32'd13);
      end
      check_eq("two_layer.n_done", 32'(nd_q.size()), 32'd1);
      if (nd_q.size() == 1) check_eq("two_layer.done_cyc", 32'(nd_q[0] - t0), 32'd22);

      // Illegal layer counts.
      run(0, -1, 1'b0, -1, 1'b0, "zero");
      run(9, -1, 1'b0, -1, 1'b0, "nine");

      // Bad descriptor in the middle of a run.
      write_desc(1, {16'd7, 6'd4, 4'd3, 1'b0, 2'd0});
      write_desc(2, {16'd5, 6'd2, 4'd1, 1'b0, 2'd2});
      for (int k = 0; k < 8; k++) gap_tbl[k] = 3;
      ls_q.delete();
      run(3, -1, 1'b0, -1, 1'b0, "bad_l1");
      check_eq("bad_l1.n_start", 32'(ls_q.size()), 32'd1);

      // Abort together with layer_done.
      write_desc(1, {16'd9, 6'd3, 4'd5, 1'b1, 2'd2});
      nd_q.delete();
      run(2, 0, 1'b1, -1, 1'b0, "abort");
      check_eq("abort.n_done", 32'(nd_q.size()), 32'd0);

      // Write to entry 0 while busy is dropped; second run reads the original entry.
      write_desc(0, {16'd100, 6'd8, 4'd2, 1'b1, 2'd3});
      run(1, -1, 1'b0, -1, 1'b1, "wr_busy");
      run(1, -1, 1'b0, -1, 1'b0, "readback");

      // Asynchronous reset mid-WAIT, then confirm the table was cleared.
      run(2, -1, 1'b0, 1, 1'b0, "rst_mid");
      run(1, -1, 1'b0, -1, 1'b0, "after_rst");

      // Randomized runs.
      for (int r = 0; r < 30; r++) begin
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) write_desc(k, rand_desc());
            gap_tbl[k] = $urandom_range(1, 5);
         end
         ab = $urandom_range(0, 9);
         if (ab == 0)      n = 0;
         else if (ab == 1) n = $urandom_range(9, 15);
         else              n = $urandom_range(1, 8);
         if (n >= 1 && n <= 8 && $urandom_range(0, 5) == 0)
            run(n, $urandom_range(0, n - 1), 1'($urandom_range(0, 1)), -1, 1'b0, "rand");
         else
            run(n, -1, 1'b0, -1, 1'b0, "rand");
         idle_cycles(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
